// File: rtl/if_id_buffer.sv
// IF/ID buffer: two-entry FIFO between fetch and decode.
// Head sits in slot 0. A flush discards every entry. Enqueuing a HALT
// (opcode 5'b00000) locks out further enqueues until flush or reset.
// Outputs come only from registered state, so no in_* signal reaches out_*
// combinationally.
module if_id_buffer #(
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    input  logic        in_err,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic        out_err,
    input  logic        out_ready,
    input  logic        flush,
    output logic        halt_locked,
    output logic [1:0]  count
);

    // Occupancy state; the encoding is the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state;

    // Entry payload. These registers are not reset; validity comes from state.
    logic [15:0] instr_p0, instr_p1;
    logic [15:0] pc_p0,    pc_p1;
    logic        err_p0,   err_p1;

    logic        enq;
    logic        deq;
    logic        is_halt;

    // Handshake decode. in_ready is gated by rst so it is low while reset is held.
    always_comb begin
        in_ready  = rst && (state != FULL) && !halt_locked && !flush;
        out_valid = (state != EMPTY);
        enq       = in_valid && in_ready;
        deq       = out_valid && out_ready;
        is_halt   = (in_instr[15:11] == 5'b00000);
        count     = state;
    end

    // Head presentation. Payload is masked whenever the buffer is empty.
    always_comb begin
        out_instr = out_valid ? instr_p0 : NOP_INSTR;
        out_pc    = out_valid ? pc_p0    : 16'h0000;
        out_err   = out_valid ? err_p0   : 1'b0;
    end

    // Occupancy and halt lock. A flush wins over enqueue and dequeue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            halt_locked <= 1'b0;
        end else if (flush) begin
            state       <= EMPTY;
            halt_locked <= 1'b0;
        end else begin
            if (enq && is_halt)
                halt_locked <= 1'b1;
            case (state)
                EMPTY:   if (enq) state <= ONE;
                ONE: begin
                    if (enq && !deq)
                        state <= FULL;
                    else if (!enq && deq)
                        state <= EMPTY;
                end
                FULL:    if (deq) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    // Payload movement: write on enqueue, shift slot 1 to slot 0 on dequeue from FULL.
    always_ff @(posedge clk) begin
        if (!flush) begin
            case (state)
                EMPTY: begin
                    if (enq) begin
                        instr_p0 <= in_instr;
                        pc_p0    <= in_pc;
                        err_p0   <= in_err;
                    end
                end
                ONE: begin
                    if (enq && deq) begin
                        instr_p0 <= in_instr;
                        pc_p0    <= in_pc;
                        err_p0   <= in_err;
                    end else if (enq) begin
                        instr_p1 <= in_instr;
                        pc_p1    <= in_pc;
                        err_p1   <= in_err;
                    end
                end
                FULL: begin
                    if (deq) begin
                        instr_p0 <= instr_p1;
                        pc_p0    <= pc_p1;
                        err_p0   <= err_p1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
